// File: rtl/tile_bitmap_ram.sv
module tile_bitmap_ram #(
  parameter int                 NUM_CHARS    = 16,
  parameter int                 TILE_W       = 16,
  parameter int                 TILE_H       = 16,
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] TRANSP_COLOR = '0,
  parameter string              INIT_FILE    = "bitmap_memory.txt",
  localparam int                CW           = $clog2(NUM_CHARS),
  localparam int                XW           = $clog2(TILE_W),
  localparam int                YW           = $clog2(TILE_H),
  localparam int                AW           = CW + YW + XW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_valid_in,
  input  logic [CW-1:0]      rd_char,
  input  logic [XW-1:0]      rd_x,
  input  logic [YW-1:0]      rd_y,
  output logic               rd_valid_out,
  output logic [COLOR_W-1:0] rd_color,
  output logic               rd_transp,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               fill_start,
  input  logic [COLOR_W-1:0] fill_value,
  output logic               fill_busy,
  output logic               fill_done
);
  localparam int DEPTH = NUM_CHARS * TILE_W * TILE_H;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      fill_ptr_q, fill_ptr_d;
  logic [COLOR_W-1:0] fill_val_q, fill_val_d;

  logic [COLOR_W-1:0] mem [DEPTH];
  logic [COLOR_W-1:0] ram_q;
  logic [AW-1:0]      ram_raddr;
  logic               rd_oor;

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;

  logic               rd_valid_q, rd_valid_d;
  logic               rd_oor_q, rd_oor_d;
  logic               rd_valid_out_q, rd_valid_out_d;
  logic [COLOR_W-1:0] rd_color_q, rd_color_d;
  logic               rd_transp_q, rd_transp_d;

  assign fill_busy    = (state_q == FILL);
  assign fill_done    = (state_q == DONE);
  assign wr_ready     = ~fill_busy & ~reset;
  assign rd_valid_out = rd_valid_out_q;
  assign rd_color     = rd_color_q;
  assign rd_transp    = rd_transp_q;

  // Out-of-range tiles are steered to address 0 so the array is never overrun.
  always_comb begin
    rd_oor    = int'(rd_char) >= NUM_CHARS;
    ram_raddr = rd_oor ? '0 : {rd_char, rd_y, rd_x};
  end

  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    fill_val_d = fill_val_q;
    mem_we     = wr_en & wr_ready;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    case (state_q)
      IDLE: begin
        if (fill_start) begin
          fill_val_d = fill_value;
          fill_ptr_d = '0;
          state_d    = FILL;
        end
      end
      FILL: begin
        mem_we    = ~reset;
        mem_waddr = fill_ptr_q;
        mem_wdata = fill_val_q;
        if (fill_ptr_q == AW'(DEPTH - 1)) state_d = DONE;
        else                              fill_ptr_d = fill_ptr_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_valid_d     = rd_valid_in;
    rd_oor_d       = rd_oor;
    rd_valid_out_d = rd_valid_q;
    rd_color_d     = rd_color_q;
    rd_transp_d    = rd_transp_q;
    if (rd_valid_q) begin
      if (rd_oor_q) begin
        rd_color_d  = '0;
        rd_transp_d = 1'b1;
      end else begin
        rd_color_d  = ram_q;
        rd_transp_d = (ram_q == TRANSP_COLOR);
      end
    end
  end

  // Read-first: ram_q samples the array before a same-edge write lands.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_q <= mem[ram_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      fill_ptr_q     <= '0;
      fill_val_q     <= '0;
      rd_valid_q     <= 1'b0;
      rd_oor_q       <= 1'b0;
      rd_valid_out_q <= 1'b0;
      rd_color_q     <= '0;
      rd_transp_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_ptr_q     <= fill_ptr_d;
      fill_val_q     <= fill_val_d;
      rd_valid_q     <= rd_valid_d;
      rd_oor_q       <= rd_oor_d;
      rd_valid_out_q <= rd_valid_out_d;
      rd_color_q     <= rd_color_d;
      rd_transp_q    <= rd_transp_d;
    end
  end

endmodule

// File: tb/tb_tile_bitmap_ram.sv
// Scoreboard bench for tile_bitmap_ram: a 4-tile and a 3-tile instance, 16x16, 12-bit.
module tb_tile_bitmap_ram;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   typedef struct packed {logic [11:0] c; logic t;} exp_t;
   exp_t q4[$];
   exp_t q3[$];
   int n_checks = 0;
   int n_pass   = 0;

   logic       rv4, vo4, to4, we4, wr4, fs4, fb4, fd4;
   logic [1:0] rc4;
   logic [3:0] rx4, ry4;
   logic [11:0] co4, wd4, fv4;
   logic [9:0] wa4;

   logic       rv3, vo3, to3, we3, wr3, fs3, fb3, fd3;
   logic [1:0] rc3;
   logic [3:0] rx3, ry3;
   logic [11:0] co3, wd3, fv3;
   logic [9:0] wa3;

   tile_bitmap_ram #(.NUM_CHARS(4), .TILE_W(16), .TILE_H(16), .COLOR_W(12),
                     .TRANSP_COLOR(12'h000), .INIT_FILE("")) u_dut4 (
      .clk(clk), .reset(reset),
      .rd_valid_in(rv4), .rd_char(rc4), .rd_x(rx4), .rd_y(ry4),
      .rd_valid_out(vo4), .rd_color(co4), .rd_transp(to4),
      .wr_en(we4), .wr_addr(wa4), .wr_data(wd4), .wr_ready(wr4),
      .fill_start(fs4), .fill_value(fv4), .fill_busy(fb4), .fill_done(fd4));

   tile_bitmap_ram #(.NUM_CHARS(3), .TILE_W(16), .TILE_H(16), .COLOR_W(12),
                     .TRANSP_COLOR(12'h000), .INIT_FILE("")) u_dut3 (
      .clk(clk), .reset(reset),
      .rd_valid_in(rv3), .rd_char(rc3), .rd_x(rx3), .rd_y(ry3),
      .rd_valid_out(vo3), .rd_color(co3), .rd_transp(to3),
      .wr_en(we3), .wr_addr(wa3), .wr_data(wd3), .wr_ready(wr3),
      .fill_start(fs3), .fill_value(fv3), .fill_busy(fb3), .fill_done(fd3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      rv4 = 0; we4 = 0; fs4 = 0;
      rv3 = 0; we3 = 0; fs3 = 0;
   endtask

   task automatic rd4(input int a, input logic [11:0] c, input logic t);
      rv4 = 1; rc4 = a[9:8]; ry4 = a[7:4]; rx4 = a[3:0];
      q4.push_back({c, t});
   endtask

   task automatic rd3(input int ch, input int y, input int x, input logic [11:0] c, input logic t);
      rv3 = 1; rc3 = ch[1:0]; ry3 = y[3:0]; rx3 = x[3:0];
      q3.push_back({c, t});
   endtask

   task automatic preload4;
      for (int n = 0; n < 1024; n++) begin
         we4 = 1; wa4 = 10'(n); wd4 = 12'(n);
         tick();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (vo4 === 1'b1) begin
         if (q4.size() == 0) check("rd4_unexpected_valid", 1, 0);
         else begin
            e = q4.pop_front();
            check("rd4_color", co4, e.c);
            check("rd4_transp", to4, e.t);
         end
      end
      if (vo3 === 1'b1) begin
         if (q3.size() == 0) check("rd3_unexpected_valid", 1, 0);
         else begin
            e = q3.pop_front();
            check("rd3_color", co3, e.c);
            check("rd3_transp", to3, e.t);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int addrs[6] = '{0, 1, 'h0FF, 'h100, 'h3FF, 'h2A5};
      int busy, done, rdy_bad;
      rv4 = 0; rc4 = 0; rx4 = 0; ry4 = 0; we4 = 0; wa4 = 0; wd4 = 0; fs4 = 0; fv4 = 0;
      rv3 = 0; rc3 = 0; rx3 = 0; ry3 = 0; we3 = 0; wa3 = 0; wd3 = 0; fs3 = 0; fv3 = 0;
      reset = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_out", vo4, 0);
      check("rst_color", co4, 0);
      check("rst_transp", to4, 0);
      check("rst_fill_busy", fb4, 0);
      check("rst_fill_done", fd4, 0);
      check("rst_wr_ready", wr4, 0);
      reset = 0;
      #1;
      check("idle_wr_ready", wr4, 1);

      preload4();

      // single read: latency and hold
      rd4('h123, 12'h123, 0);
      tick();
      @(negedge clk) check("lat_c1_valid", vo4, 0);
      @(posedge clk); #1;
      @(negedge clk) check("lat_c2_valid", vo4, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("hold_valid", vo4, 0);
      check("hold_color", co4, 12'h123);

      // back-to-back reads
      foreach (addrs[i]) begin
         rd4(addrs[i], 12'(addrs[i]), addrs[i] == 0);
         tick();
      end
      repeat (3) tick();

      // read-first on same-cycle write, new data one cycle later
      rd4('h040, 12'h040, 0);
      we4 = 1; wa4 = 10'h040; wd4 = 12'hABC;
      tick();
      rd4('h040, 12'hABC, 0);
      tick();
      repeat (3) tick();

      // fill with transparent colour; dropped write and ignored restart inside
      fv4 = 12'h000; fs4 = 1;
      tick();
      busy = 0; done = 0; rdy_bad = 0;
      for (int i = 0; i < 1040; i++) begin
         if (i == 10) begin
            we4 = 1; wa4 = 10'd3; wd4 = 12'h777;
            check("fill_wr_ready_low", wr4, 0);
         end
         if (i == 50) begin
            fs4 = 1; fv4 = 12'hFFF;
         end
         @(negedge clk);
         if (fb4) busy++;
         if (fd4) done++;
         if (fb4 && wr4) rdy_bad++;
         tick();
      end
      check("fill_busy_cycles", busy, 1024);
      check("fill_done_pulses", done, 1);
      check("fill_wr_ready_viol", rdy_bad, 0);
      rd4(3, 12'h000, 1);     tick();
      rd4(0, 12'h000, 1);     tick();
      rd4('h123, 12'h000, 1); tick();
      rd4('h3FF, 12'h000, 1); tick();
      repeat (3) tick();

      // reset aborts a fill at fill cycle 100
      preload4();
      rd4('h2A5, 12'h2A5, 0); tick();
      repeat (3) tick();
      fv4 = 12'hFFF; fs4 = 1;
      tick();
      repeat (100) tick();
      reset = 1;
      check("abort_busy_before", fb4, 1);
      tick();
      check("abort_busy", fb4, 0);
      check("abort_valid_out", vo4, 0);
      check("abort_color", co4, 0);
      check("abort_transp", to4, 0);
      reset = 0;
      done = int'(fd4);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (fd4) done++;
         tick();
      end
      check("abort_no_done", done, 0);
      rd4(0, 12'hFFF, 0);     tick();
      rd4(99, 12'hFFF, 0);    tick();
      rd4(100, 12'h064, 0);   tick();
      rd4(101, 12'h065, 0);   tick();
      rd4('h3FF, 12'h3FF, 0); tick();
      repeat (3) tick();

      // three-tile instance: out-of-range tile and non-power-of-2 fill length
      rd3(3, 5, 7, 12'h000, 1); tick();
      repeat (3) tick();
      fv3 = 12'hABC; fs3 = 1;
      tick();
      busy = 0; done = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (fb3) busy++;
         if (fd3) done++;
         tick();
      end
      check("fill3_busy_cycles", busy, 768);
      check("fill3_done_pulses", done, 1);
      rd3(2, 15, 15, 12'hABC, 0); tick();
      rd3(3, 0, 0, 12'h000, 1);   tick();
      rd3(0, 0, 0, 12'hABC, 0);   tick();
      repeat (4) tick();

      check("q4_drained", q4.size(), 0);
      check("q3_drained", q3.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
